// File: rtl/tail_pkg.sv
// Shared encodings and constants for the sequential tail-lamp dimmer.
package tail_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FADE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_BOTH  = 2'd3
    } mode_t;

    // PWM duty added per brightness step; STEPS is a power of two, so this divides exactly.
    function automatic int duty_step(input int pwm_bits, input int steps);
        return (1 << pwm_bits) / steps;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One registered PWM lamp driver compared against the shared free-running counter.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS:0]   duty,
    input  logic                full,
    output logic                lamp_p1
);

    // duty is one bit wider than cnt so the full-scale value is representable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_p1 <= 1'b0;
        end else begin
            lamp_p1 <= full | ({1'b0, cnt} < duty);
        end
    end

endmodule

// File: rtl/seq_tail_dimmer.sv
// Sequential turn-indicator dimmer: lamps sweep on one by one, then fade together.
module seq_tail_dimmer
    import tail_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int STEPS    = 4,
    parameter int PWM_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    output logic [2*LAMPS-1:0] light,
    output logic               busy
);

    localparam int LAMP_W = $clog2(LAMPS);
    localparam int LVL_W  = $clog2(STEPS + 1);
    localparam int DUTY_W = PWM_BITS + 1;
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(STEPS);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMPS - 1);
    localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'(duty_step(PWM_BITS, STEPS));

    function automatic logic [DUTY_W-1:0] level_to_duty(input logic [LVL_W-1:0] lvl);
        return DUTY_W'(lvl) * DUTY_STEP;
    endfunction

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [LAMP_W-1:0]   lamp_q, lamp_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [PWM_BITS-1:0] cnt_q;
    logic [LVL_W-1:0]    lamp_lvl_p0 [LAMPS];
    logic [LAMPS-1:0]    lamp_p1;
    logic                show_left, show_right;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NONE;
            lamp_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lamp_q  <= lamp_d;
            level_q <= level_d;
            cnt_q   <= cnt_q + PWM_BITS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lamp_d  = lamp_q;
        level_d = level_q;
        if (step_en) begin
            case (state_q)
                ST_IDLE: begin
                    // Requests are only sampled here; the mode stays latched for the whole sequence.
                    if (hazard || (left ^ right)) begin
                        mode_d  = hazard ? MODE_BOTH : (left ? MODE_LEFT : MODE_RIGHT);
                        state_d = ST_SWEEP;
                        lamp_d  = '0;
                        level_d = LVL_ONE;
                    end
                end
                ST_SWEEP: begin
                    if (level_q != LVL_FULL) begin
                        level_d = level_q + LVL_ONE;
                    end else if (lamp_q != LAMP_LAST) begin
                        lamp_d  = lamp_q + LAMP_W'(1);
                        level_d = LVL_ONE;
                    end else begin
                        state_d = ST_FADE;
                        level_d = LVL_FULL - LVL_ONE;
                    end
                end
                ST_FADE: begin
                    level_d = level_q - LVL_ONE;
                    if (level_q == LVL_ONE) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage p0: per-lamp brightness level from the sequence position.
    always_comb begin
        for (int i = 0; i < LAMPS; i++) begin
            lamp_lvl_p0[i] = '0;
            if (state_q == ST_SWEEP) begin
                if (LAMP_W'(i) < lamp_q)       lamp_lvl_p0[i] = LVL_FULL;
                else if (LAMP_W'(i) == lamp_q) lamp_lvl_p0[i] = level_q;
            end else if (state_q == ST_FADE) begin
                lamp_lvl_p0[i] = level_q;
            end
        end
    end

    assign show_left  = (mode_q == MODE_LEFT)  || (mode_q == MODE_BOTH);
    assign show_right = (mode_q == MODE_RIGHT) || (mode_q == MODE_BOTH);
    assign busy       = (state_q != ST_IDLE);

    // Stage p1: registered PWM outputs, shared by both sides with lamp 0 innermost.
    for (genvar g = 0; g < LAMPS; g++) begin : g_lamp
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .cnt     (cnt_q),
            .duty    (level_to_duty(lamp_lvl_p0[g])),
            .full    (lamp_lvl_p0[g] == LVL_FULL),
            .lamp_p1 (lamp_p1[g])
        );
        assign light[LAMPS+g]   = lamp_p1[g] & show_left;
        assign light[LAMPS-1-g] = lamp_p1[g] & show_right;
    end

endmodule
